// File: rtl/block_to_raster_output.sv
// block_to_raster_output
// Converts a stream of BLOCK_SIZE x BLOCK_SIZE pixel blocks (blocks left-to-right,
// row-major inside each block) into raster order, one horizontal strip of blocks
// at a time, and emits it on an AXI-stream master.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   frame_width/height  frame dimensions, latched at each frame start
//   in_data/in_valid    block-order pixel input, in_ready back-pressure
//   in_start_of_frame   marks pixel 0 of a frame (qualified by in_valid)
//   m_axis_*            raster-order output; tlast = end of line, tuser = start of frame
//   frame_done          one-cycle pulse after the final beat of a frame is accepted
//   sync_err            one-cycle pulse when a frame restarts in the middle of a frame
module block_to_raster_output #(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned BLOCK_SIZE      = 8,
   parameter int unsigned MAX_FRAME_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           frame_width,
   input  logic [15:0]           frame_height,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_start_of_frame,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  frame_done,
   output logic                  sync_err
);

   localparam int unsigned Depth = BLOCK_SIZE * MAX_FRAME_WIDTH;
   localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [15:0] Bs    = 16'(BLOCK_SIZE);

   typedef enum logic [1:0] {StIdle, StFill, StDrain} state_e;

   state_e state_q, state_d;
   logic [15:0] fw_q, fw_d, fh_q, fh_d;
   // Write position: column/row inside the block, block column base, row base (r*frame_width)
   logic [15:0] col_q, col_d, row_q, row_d, bx_q, bx_d, rbase_q, rbase_d;
   logic [15:0] lines_q, lines_d;      // lines already emitted in this frame (strip counter)
   logic [15:0] rd_ptr_q, rd_ptr_d;    // pixel-out counter within the strip
   logic [15:0] ocol_q, ocol_d;        // output line column
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
   logic done_q, done_d, serr_q, serr_d;

   logic [DATA_WIDTH-1:0] mem [Depth];
   logic [DATA_WIDTH-1:0] rd_word;

   logic          accept, start, store, strip_end, c_end, r_end;
   logic [15:0]   cur_col, cur_row, cur_bx, cur_rbase, fw_eff, strip_len;
   logic [AW-1:0] wr_addr;
   logic          more, load, acc_out, last_acc;

   assign in_ready = rst_n && (state_q != StDrain);
   assign rd_word  = mem[rd_ptr_q[AW-1:0]];

   always_comb begin
      state_d  = state_q;
      fw_d     = fw_q;
      fh_d     = fh_q;
      col_d    = col_q;
      row_d    = row_q;
      bx_d     = bx_q;
      rbase_d  = rbase_q;
      lines_d  = lines_q;
      rd_ptr_d = rd_ptr_q;
      ocol_d   = ocol_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      done_d   = 1'b0;
      serr_d   = 1'b0;

      accept = in_valid && in_ready;
      // Beats without start-of-frame are dropped while idle
      start  = accept && in_start_of_frame;
      store  = accept && ((state_q == StFill) || start);

      // A frame start behaves as if the write position were at the origin
      cur_col   = start ? 16'd0 : col_q;
      cur_row   = start ? 16'd0 : row_q;
      cur_bx    = start ? 16'd0 : bx_q;
      cur_rbase = start ? 16'd0 : rbase_q;
      fw_eff    = start ? frame_width : fw_q;
      wr_addr   = AW'(cur_rbase + cur_bx + cur_col);
      c_end     = (cur_col == Bs - 16'd1);
      r_end     = (cur_row == Bs - 16'd1);
      strip_end = c_end && r_end && (cur_bx + Bs == fw_eff);

      if (start) begin
         fw_d    = frame_width;
         fh_d    = frame_height;
         lines_d = 16'd0;
         serr_d  = (state_q == StFill) &&
                   ((col_q != 16'd0) || (row_q != 16'd0) || (bx_q != 16'd0) ||
                    (lines_q != 16'd0));
      end

      if (store) begin
         state_d = strip_end ? StDrain : StFill;
         if (!c_end) begin
            col_d   = cur_col + 16'd1;
            row_d   = cur_row;
            bx_d    = cur_bx;
            rbase_d = cur_rbase;
         end else if (!r_end) begin
            col_d   = 16'd0;
            row_d   = cur_row + 16'd1;
            bx_d    = cur_bx;
            rbase_d = cur_rbase + fw_eff;
         end else begin
            // Next block in the strip, or back to the origin once the strip is full
            col_d   = 16'd0;
            row_d   = 16'd0;
            bx_d    = strip_end ? 16'd0 : cur_bx + Bs;
            rbase_d = 16'd0;
         end
      end

      // Drain: single output register refilled straight from the buffer
      strip_len = 16'(fw_q * Bs);
      more      = (rd_ptr_q != strip_len);
      acc_out   = tvalid_q && m_axis_tready;
      load      = (state_q == StDrain) && more && (!tvalid_q || m_axis_tready);
      last_acc  = (state_q == StDrain) && acc_out && !more;

      if (load) begin
         tdata_d  = rd_word;
         tvalid_d = 1'b1;
         tlast_d  = (ocol_q == fw_q - 16'd1);
         tuser_d  = (lines_q == 16'd0) && (rd_ptr_q == 16'd0);
         rd_ptr_d = rd_ptr_q + 16'd1;
         ocol_d   = (ocol_q == fw_q - 16'd1) ? 16'd0 : ocol_q + 16'd1;
      end else if (acc_out) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         tuser_d  = 1'b0;
      end

      if (last_acc) begin
         rd_ptr_d = 16'd0;
         ocol_d   = 16'd0;
         if (lines_q + Bs >= fh_q) begin
            state_d = StIdle;
            lines_d = 16'd0;
            done_d  = 1'b1;
         end else begin
            state_d = StFill;
            lines_d = lines_q + Bs;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (store) mem[wr_addr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         fw_q     <= '0;
         fh_q     <= '0;
         col_q    <= '0;
         row_q    <= '0;
         bx_q     <= '0;
         rbase_q  <= '0;
         lines_q  <= '0;
         rd_ptr_q <= '0;
         ocol_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         done_q   <= 1'b0;
         serr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         fw_q     <= fw_d;
         fh_q     <= fh_d;
         col_q    <= col_d;
         row_q    <= row_d;
         bx_q     <= bx_d;
         rbase_q  <= rbase_d;
         lines_q  <= lines_d;
         rd_ptr_q <= rd_ptr_d;
         ocol_q   <= ocol_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         done_q   <= done_d;
         serr_q   <= serr_d;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
   assign frame_done    = done_q;
   assign sync_err      = serr_q;

endmodule

// File: doc/block_to_raster_output.md
BLOCK_TO_RASTER_OUTPUT -- requirements
Module: block_to_raster_output

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of pixel word ({8'b0,R,G,B}).
REQ-002 Parameter BLOCK_SIZE, default 8, block edge in pixels.
REQ-003 Parameter MAX_FRAME_WIDTH, default 64, largest supported frame_width; strip buffer depth = BLOCK_SIZE*MAX_FRAME_WIDTH words.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 frame_width  input  16  pixels per line, multiple of BLOCK_SIZE, <= MAX_FRAME_WIDTH.
REQ-007 frame_height  input  16  lines per frame, multiple of BLOCK_SIZE.
REQ-008 in_data  input  DATA_WIDTH  Wiener-filtered pixel.
REQ-009 in_valid  input  1  in_data valid.
REQ-010 in_ready  output  1  block accepts in_data this cycle.
REQ-011 in_start_of_frame  input  1  qualifies first pixel of a frame (sampled with in_valid).
REQ-012 m_axis_tdata  output  DATA_WIDTH  raster-order pixel.
REQ-013 m_axis_tvalid  output  1  AXI-stream valid.
REQ-014 m_axis_tready  input  1  AXI-stream ready.
REQ-015 m_axis_tlast  output  1  last pixel of a line.
REQ-016 m_axis_tuser  output  1  first pixel of a frame.
REQ-017 frame_done  output  1  one-cycle pulse after last beat of frame accepted.
REQ-018 sync_err  output  1  one-cycle pulse when a frame is restarted mid-frame.

Function
REQ-019 Input order: blocks left-to-right then top-to-bottom; within a block row-major; transfer occurs on in_valid && in_ready.
REQ-020 Pixel (row r, col c) of block column bx SHALL be written to buffer address r*frame_width + bx*BLOCK_SIZE + c.
REQ-021 States: IDLE, FILL, DRAIN.
REQ-022 IDLE: in_ready=1; input beats without in_start_of_frame are dropped; a beat with in_start_of_frame is stored as pixel 0, frame_width/frame_height are latched, state -> FILL.
REQ-023 FILL: in_ready=1; after frame_width*BLOCK_SIZE pixels stored (one strip), state -> DRAIN on the next cycle.
REQ-024 DRAIN: in_ready=0; buffer read in address order 0..frame_width*BLOCK_SIZE-1 and emitted on m_axis.
REQ-025 First m_axis_tvalid SHALL assert no later than 2 cycles after entering DRAIN; with tready held 1, one beat per cycle thereafter.
REQ-026 While tvalid && !tready, tdata/tlast/tuser SHALL hold stable; tvalid SHALL not drop before acceptance.
REQ-027 tlast=1 on every beat whose line column = frame_width-1; tuser=1 only on beat 0 of strip 0.
REQ-028 End of DRAIN (last beat accepted): if strips emitted = frame_height/BLOCK_SIZE, pulse frame_done in the following cycle and -> IDLE; else -> FILL for next strip.
REQ-029 in_start_of_frame seen in FILL with pixels already stored: pulse sync_err, discard strip and strip count, store beat as pixel 0 of new frame, relatch dimensions, remain FILL.
REQ-030 in_start_of_frame is not sampled in DRAIN (in_ready=0).
REQ-031 Counters: pixel-in, pixel-out, column, strip counters 16-32 bits; no wrap within a legal frame.
REQ-032 Dimension inputs changing mid-frame SHALL have no effect until next frame start.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE, in_ready=0 during reset, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, frame_done=0, sync_err=0, all counters 0; buffer contents need not be cleared.
REQ-034 After rst_n release, in_ready=1 from the first clock edge; reset during DRAIN abandons the frame with no further beats.

Verification
REQ-035 16x16 frame, pixel value = raster index (block order input), tready=1 -> output 0x000..0x0FF in order, tlast on indices 15,31,...,255, tuser on index 0 only, frame_done one cycle after beat 255.
REQ-036 Same frame, tready random 50% -> identical beat sequence; no tdata change while tvalid && !tready.
REQ-037 in_valid gapped every other cycle -> same output as REQ-035; in_ready=0 throughout each DRAIN of 128 beats.
REQ-038 Restart: in_start_of_frame at input pixel 40 of strip 0 -> sync_err pulse once; output is the new frame only, first beat tuser=1 carrying the restarted pixel.
REQ-039 rst_n low for 2 cycles during beat 70 of DRAIN -> tvalid=0 immediately, no frame_done; subsequent full frame per REQ-035 passes.
REQ-040 Back-to-back frames 32x8 then 16x16 -> first frame 256 beats with tlast every 32, second per REQ-035; two frame_done pulses.
